// File: rtl/pulse_stretcher_mc.sv
// Multi-channel programmable pulse stretcher: each din bit triggers a pulse of
// stretch_len cycles, with optional retrigger, edge detect, holdoff and drop flag.

module pulse_stretcher_ch #(
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic [CNT_W-1:0] len_m1,
  input  logic             retrig_en,
  input  logic             edge_mode,
  input  logic             ovf_clr,
  output logic             stretched_pulse,
  output logic             busy,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE = 2'd0, STRETCH = 2'd1, HOLD = 2'd2} state_t;

  localparam bit               HAS_HOLD = (HOLDOFF != 0);
  localparam logic [CNT_W-1:0] HOLD_M1  = HAS_HOLD ? CNT_W'(HOLDOFF - 1) : '0;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             din_d;
  logic             trig, cnt_zero, idle_like, drop;

  always_comb begin
    trig      = edge_mode ? (din & ~din_d) : din;
    cnt_zero  = (cnt == '0);
    // an exhausted holdoff accepts triggers exactly like IDLE
    idle_like = (state == IDLE) || (state == HOLD && cnt_zero);
    drop      = 1'b0;
    if (trig) begin
      if (state == STRETCH)   drop = !retrig_en && (!cnt_zero || HAS_HOLD);
      else if (state == HOLD) drop = !cnt_zero;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      din_d           <= 1'b0;
      stretched_pulse <= 1'b0;
      busy            <= 1'b0;
      ovf             <= 1'b0;
    end else begin
      din_d <= din;
      ovf   <= (ovf & ~ovf_clr) | drop;
      if (idle_like) begin
        if (trig) begin
          state           <= STRETCH;
          cnt             <= len_m1;
          stretched_pulse <= 1'b1;
          busy            <= 1'b1;
        end else begin
          state           <= IDLE;
          cnt             <= '0;
          stretched_pulse <= 1'b0;
          busy            <= 1'b0;
        end
      end else if (state == STRETCH) begin
        if (!cnt_zero) begin
          cnt <= (trig && retrig_en) ? len_m1 : cnt - ONE;
        end else if (trig && (retrig_en || !HAS_HOLD)) begin
          cnt <= len_m1;
        end else if (HAS_HOLD) begin
          state           <= HOLD;
          cnt             <= HOLD_M1;
          stretched_pulse <= 1'b0;
        end else begin
          state           <= IDLE;
          stretched_pulse <= 1'b0;
          busy            <= 1'b0;
        end
      end else if (state == HOLD) begin
        cnt <= cnt - ONE;
      end else begin
        // unreachable encoding: fall back to a quiet IDLE
        state           <= IDLE;
        cnt             <= '0;
        stretched_pulse <= 1'b0;
        busy            <= 1'b0;
      end
    end
  end
endmodule

module pulse_stretcher_mc #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   din,
  input  logic [CNT_W-1:0] stretch_len,
  input  logic             retrig_en,
  input  logic             edge_mode,
  input  logic [NCH-1:0]   ovf_clr,
  output logic [NCH-1:0]   stretched_pulse,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   ovf
);
  logic [CNT_W-1:0] len_m1;

  // a zero length behaves as a single-cycle pulse
  assign len_m1 = (stretch_len == '0) ? '0 : stretch_len - CNT_W'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pulse_stretcher_ch #(.CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) u_ch (
      .clk             (clk),
      .reset_n         (reset_n),
      .din             (din[i]),
      .len_m1          (len_m1),
      .retrig_en       (retrig_en),
      .edge_mode       (edge_mode),
      .ovf_clr         (ovf_clr[i]),
      .stretched_pulse (stretched_pulse[i]),
      .busy            (busy[i]),
      .ovf             (ovf[i])
    );
  end
endmodule

// File: tb/tb_pulse_stretcher_mc.sv
// Scoreboard bench: two DUTs (HOLDOFF=2 and HOLDOFF=0) share stimulus and are
// checked against an event-time model of pulse end and holdoff end per channel.

module tb_pulse_stretcher_mc;
  localparam int NCH = 4;
  localparam int CNT_W = 8;
  localparam int HO = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NCH-1:0]   din, ovf_clr;
  logic [CNT_W-1:0] stretch_len;
  logic             retrig_en, edge_mode;
  logic [NCH-1:0]   sp2, busy2, ovf2, sp0, busy0, ovf0;

  always #5 clk = ~clk;

  pulse_stretcher_mc #(.NCH(NCH), .CNT_W(CNT_W), .HOLDOFF(HO)) dut_h2 (
    .clk(clk), .reset_n(reset_n), .din(din), .stretch_len(stretch_len),
    .retrig_en(retrig_en), .edge_mode(edge_mode), .ovf_clr(ovf_clr),
    .stretched_pulse(sp2), .busy(busy2), .ovf(ovf2));

  pulse_stretcher_mc #(.NCH(NCH), .CNT_W(CNT_W), .HOLDOFF(0)) dut_h0 (
    .clk(clk), .reset_n(reset_n), .din(din), .stretch_len(stretch_len),
    .retrig_en(retrig_en), .edge_mode(edge_mode), .ovf_clr(ovf_clr),
    .stretched_pulse(sp0), .busy(busy0), .ovf(ovf0));

  typedef struct {
    logic [NCH-1:0] sp2, b2, o2, sp0, b0, o0;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   failed = 0;

  // model: per channel, the edge index at which the pulse falls (hend)
  int             t = 0;
  int             hend [2][NCH];
  logic [NCH-1:0] m_ovf [2];
  logic [NCH-1:0] m_dind;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) hend[m][c] = -1000;
      m_ovf[m] = '0;
    end
    m_dind = '0;
  endtask

  task automatic model_step();
    exp_t           e;
    logic [NCH-1:0] trig, sp, bz;
    int             len, hv;
    logic           drop;
    len  = (stretch_len == 0) ? 1 : int'(stretch_len);
    trig = edge_mode ? (din & ~m_dind) : din;
    for (int m = 0; m < 2; m++) begin
      hv = (m == 0) ? HO : 0;
      for (int c = 0; c < NCH; c++) begin
        drop = 1'b0;
        if (trig[c]) begin
          if (t < hend[m][c]) begin
            if (retrig_en) hend[m][c] = t + len;
            else drop = 1'b1;
          end else if (t < hend[m][c] + hv) begin
            if (t == hend[m][c] && retrig_en) hend[m][c] = t + len;
            else drop = 1'b1;
          end else begin
            hend[m][c] = t + len;
          end
        end
        m_ovf[m][c] = (m_ovf[m][c] & ~ovf_clr[c]) | drop;
        sp[c] = (t < hend[m][c]);
        bz[c] = (t < hend[m][c] + hv);
      end
      if (m == 0) begin e.sp2 = sp; e.b2 = bz; e.o2 = m_ovf[0]; end
      else        begin e.sp0 = sp; e.b0 = bz; e.o0 = m_ovf[1]; end
    end
    m_dind = din;
    t++;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s @%0t actual=%b expected=%b", name, $time, act, exp_v);
    end
  endtask

  // monitor: every edge with an outstanding expectation is compared
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sp_h2",   sp2,   e.sp2);
      chk("busy_h2", busy2, e.b2);
      chk("ovf_h2",  ovf2,  e.o2);
      chk("sp_h0",   sp0,   e.sp0);
      chk("busy_h0", busy0, e.b0);
      chk("ovf_h0",  ovf0,  e.o0);
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    ovf_clr = '0;
  endtask

  task automatic drive(input logic [NCH-1:0] v, input int n);
    din = v;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog @%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; din = '0; ovf_clr = '0; stretch_len = 8'd5;
    retrig_en = 1'b0; edge_mode = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sp", sp2 | sp0, '0);
    chk("rst_busy", busy2 | busy0, '0);
    chk("rst_ovf", ovf2 | ovf0, '0);
    reset_n = 1'b1;

    // single trigger, level mode
    drive(4'b0000, 10); drive(4'b0001, 1); drive(4'b0000, 12);
    // retrigger extends
    retrig_en = 1'b1;
    drive(4'b0010, 1); drive(4'b0000, 2); drive(4'b0010, 1); drive(4'b0000, 12);
    // ignore mode drops, then clear, then drop+clear together
    retrig_en = 1'b0;
    drive(4'b0100, 1); drive(4'b0000, 2); drive(4'b0100, 1); drive(4'b0000, 10);
    ovf_clr = 4'b0100; drive(4'b0000, 1); drive(4'b0000, 2);
    drive(4'b0100, 1); drive(4'b0000, 1);
    ovf_clr = 4'b0100; drive(4'b0100, 1); drive(4'b0000, 10);
    // held-high input, edge then level
    stretch_len = 8'd4; edge_mode = 1'b1;
    drive(4'b1000, 20); drive(4'b0000, 10);
    edge_mode = 1'b0;
    drive(4'b1000, 20); drive(4'b0000, 10);
    retrig_en = 1'b1;
    drive(4'b1000, 12); drive(4'b0000, 10);
    retrig_en = 1'b0;
    // zero length, and length change mid-pulse
    stretch_len = 8'd0; drive(4'b0001, 1); drive(4'b0000, 6);
    stretch_len = 8'd6; drive(4'b0001, 1); drive(4'b0000, 2);
    stretch_len = 8'd2; drive(4'b0000, 8); drive(4'b0001, 1); drive(4'b0000, 6);
    // asynchronous reset mid-pulse, flags raised first
    stretch_len = 8'd8;
    drive(4'b0011, 1); drive(4'b0000, 1); drive(4'b0011, 1); drive(4'b0000, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_sp", sp2 | sp0, '0);
    chk("arst_busy", busy2 | busy0, '0);
    chk("arst_ovf", ovf2 | ovf0, '0);
    model_reset();
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    drive(4'b0001, 1); drive(4'b0000, 12);
    // din high across reset release looks like a rising edge
    edge_mode = 1'b1;
    reset_n = 1'b0; model_reset(); din = 4'b0100;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    drive(4'b0100, 3); drive(4'b0000, 12);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) retrig_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) edge_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)  stretch_len = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0)  ovf_clr = NCH'($urandom_range(0, 15));
      drive(NCH'($urandom_range(0, 15) & $urandom_range(0, 15)), 1);
    end
    drive(4'b0000, 20);

    @(posedge clk); #2;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
